// File: rtl/tlp_snoop_arb.sv
// Round-robin arbiter that forwards whole TLPs from NUM_CH snoop channels as one
// AXI-Stream packet each, prefixed by a NetTLP metadata beat (seq, channel, timestamp).
module tlp_snoop_arb #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MAX_BEATS  = 64,
  parameter int unsigned TS_WIDTH   = 32
) (
  input  logic                           eth_clk,
  input  logic                           eth_rst_n,
  input  logic [NUM_CH-1:0]              s_tvalid,
  output logic [NUM_CH-1:0]              s_tready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_CH*KEEP_WIDTH-1:0]   s_tkeep,
  input  logic [NUM_CH-1:0]              s_tlast,
  input  logic [NUM_CH-1:0]              ch_enable,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [KEEP_WIDTH-1:0]          m_tkeep,
  output logic                           m_tlast,
  output logic                           m_tuser,
  output logic [31:0]                    fwd_cnt,
  output logic [31:0]                    drop_cnt,
  output logic [31:0]                    trunc_cnt
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_TRUNC, S_DROP} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] ts_lat_q, ts_lat_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [SEQ_W-1:0]    seq_q [NUM_CH];
  logic [SEQ_W-1:0]    seq_d [NUM_CH];
  logic [CNT_W-1:0]    fwd_q, fwd_d, drop_q, drop_d, trunc_q, trunc_d;

  logic                  arb_hit;
  logic [CH_W-1:0]       arb_idx;
  logic [CH_W-1:0]       cand;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  at_max;
  logic [DATA_WIDTH-1:0] hdr_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // First requesting channel at or after rr_ptr, wrapping modulo NUM_CH
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_q;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(rr_q) + i) % NUM_CH);
      if (!arb_hit && s_tvalid[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign sel_data  = s_tdata[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_keep  = s_tkeep[32'(grant_q) * KEEP_WIDTH +: KEEP_WIDTH];
  assign sel_valid = s_tvalid[grant_q];
  assign sel_last  = s_tlast[grant_q];
  assign at_max    = (beat_q == BEAT_W'(MAX_BEATS - 1));
  assign hdr_word  = DATA_WIDTH'({seq_q[grant_q], 8'(grant_q), 8'h00, 32'(ts_lat_q)});

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    ts_d      = ts_q + TS_WIDTH'(1);
    ts_lat_d  = ts_lat_q;
    beat_d    = beat_q;
    seq_d     = seq_q;
    fwd_d     = fwd_q;
    drop_d    = drop_q;
    trunc_d   = trunc_q;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    m_tuser   = 1'b0;
    s_tready  = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          grant_d  = arb_idx;
          rr_d     = CH_W'((32'(arb_idx) + 32'd1) % NUM_CH);
          ts_lat_d = ts_q;
          beat_d   = '0;
          state_d  = ch_enable[arb_idx] ? S_HDR : S_DROP;
        end
      end
      S_HDR: begin
        m_tvalid = 1'b1;
        m_tkeep  = '1;
        m_tdata  = hdr_word;
        if (m_tready) state_d = S_DATA;
      end
      S_DATA: begin
        m_tvalid          = sel_valid;
        m_tdata           = sel_data;
        m_tkeep           = sel_keep;
        m_tlast           = sel_last | at_max;
        m_tuser           = at_max & ~sel_last;
        s_tready[grant_q] = m_tready;
        if (sel_valid && m_tready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (sel_last || at_max) begin
            seq_d[grant_q] = seq_q[grant_q] + SEQ_W'(1);
            fwd_d          = sat_inc(fwd_q);
            state_d        = sel_last ? S_IDLE : S_TRUNC;
            if (!sel_last) trunc_d = sat_inc(trunc_q);
          end
        end
      end
      S_TRUNC: begin
        s_tready[grant_q] = 1'b1;
        if (sel_valid && sel_last) state_d = S_IDLE;
      end
      S_DROP: begin
        s_tready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          drop_d  = sat_inc(drop_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      ts_q     <= '0;
      ts_lat_q <= '0;
      beat_q   <= '0;
      fwd_q    <= '0;
      drop_q   <= '0;
      trunc_q  <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) seq_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      ts_q     <= ts_d;
      ts_lat_q <= ts_lat_d;
      beat_q   <= beat_d;
      fwd_q    <= fwd_d;
      drop_q   <= drop_d;
      trunc_q  <= trunc_d;
      seq_q    <= seq_d;
    end
  end

  assign fwd_cnt   = fwd_q;
  assign drop_cnt  = drop_q;
  assign trunc_cnt = trunc_q;

endmodule

// File: doc/tlp_snoop_arb.md
Name: tlp_snoop_arb

Overview:
- Multi-channel successor to the single-path PCIe-RX snoop front end. It runs entirely in the Ethernet clock domain, downstream of the per-channel PCIe async FIFOs and upstream of eth_encap.
- It round-robin arbitrates whole TLPs from NUM_CH snoop channels (for example RX and TX), prepends one NetTLP metadata beat (sequence, channel, timestamp) and forwards the result as one AXI-Stream packet.
- Per-channel enable/drop, length truncation and saturating statistics are new behaviour.

Parameters:
NUM_CH, 2, number of snoop input channels (1..8)
DATA_WIDTH, 64, stream data width in bits; must be >= 64 and a multiple of 64
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width
MAX_BEATS, 64, maximum TLP data beats forwarded per packet (2..255)
TS_WIDTH, 32, timestamp counter width (<= 32)

Ports:
eth_clk  in  1  Ethernet clock; all logic on its rising edge
eth_rst_n  in  1  asynchronous active-low reset
s_tvalid  in  NUM_CH  per-channel beat valid
s_tready  out  NUM_CH  per-channel beat accept
s_tdata  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
s_tkeep  in  NUM_CH*KEEP_WIDTH  per-channel byte enables
s_tlast  in  NUM_CH  per-channel end of TLP
ch_enable  in  NUM_CH  1 = forward, 0 = consume and drop
m_tvalid  out  1  output beat valid
m_tready  in  1  output beat accept
m_tdata  out  DATA_WIDTH  output data
m_tkeep  out  KEEP_WIDTH  output byte enables
m_tlast  out  1  end of output packet
m_tuser  out  1  set with m_tlast when the TLP was truncated
fwd_cnt  out  32  forwarded packets, saturating
drop_cnt  out  32  dropped packets, saturating
trunc_cnt  out  32  truncated packets, saturating

Behaviour:
- Reset (asynchronous, eth_rst_n=0):
  - FSM=IDLE; rr_ptr=0; all sequence counters, timestamp and statistics = 0.
  - m_tvalid, m_tlast, m_tuser = 0; m_tdata, m_tkeep = 0; s_tready = 0.
  - Reset asserted mid-packet abandons the packet. No partial output is completed after release.
- Timestamp: free-running TS_WIDTH counter, +1 every cycle, wraps to 0.
- Arbitration (IDLE only): grant goes to the first channel c with s_tvalid[c]=1, searching rr_ptr, rr_ptr+1, … mod NUM_CH. On grant:
  - latch grant index, ch_enable[grant] and the timestamp;
  - set rr_ptr = (grant+1) mod NUM_CH;
  - go to HDR if enabled, else DROP.
  - ch_enable changes mid-packet have no effect on the packet in progress.
- HDR:
  - m_tvalid=1, m_tlast=0, m_tkeep all ones.
  - m_tdata[63:0] = {seq[grant][15:0], 8'(grant), 8'h00, 32'(timestamp latched at grant)}, MSB first; upper bits zero.
  - Held stable until m_tready=1, then go to DATA. s_tready all 0.
- DATA:
  - m_tdata/m_tkeep/m_tlast = granted channel's inputs (combinational mux).
  - m_tvalid = s_tvalid[grant]; s_tready[grant] = m_tready; other channels' s_tready = 0.
  - A beat transfers when s_tvalid & m_tready. A beat counter starts at 0 and increments per transfer.
  - On a transfer with s_tlast: seq[grant] += 1 (16-bit wrap 0xFFFF→0), fwd_cnt += 1, go to IDLE.
  - On transfer number MAX_BEATS without s_tlast: force m_tlast=1 and m_tuser=1; fwd_cnt and trunc_cnt += 1; seq += 1; go to TRUNC.
- TRUNC: s_tready[grant]=1, m_tvalid=0. Consume and discard beats until a beat with s_tlast, then go to IDLE.
- DROP: s_tready[grant]=1, m_tvalid=0. Consume until a beat with s_tlast, then drop_cnt += 1, seq unchanged, go to IDLE.
- Packet atomicity: no interleaving of channels within an output packet. IDLE costs exactly one cycle between packets; HDR appears the cycle after grant.
- Single-beat TLP (s_tlast on first beat) is legal: output is 2 beats, HDR then DATA with m_tlast=1.
- Statistics counters hold at 0xFFFFFFFF.
- Backpressure: m_tready=0 stalls HDR/DATA indefinitely with outputs stable. TRUNC/DROP ignore m_tready.

Test Plan:
- Ch0 enabled, 3-beat TLP (tdata 0x11..,0x22..,0x33.., last tkeep 0x0F), m_tready=1 → output 4 beats: header with seq=0 and ch=0, then the 3 data beats; m_tlast on beat 4 with tkeep 0x0F; fwd_cnt=1, seq[0]=1.
- Ch0 and ch1 both continuously valid with 1-beat TLPs → output alternates ch0, ch1, ch0, …; header ch fields 0,1,0,1; each channel's seq increments independently.
- ch_enable=2'b10, ch0 sends 2 TLPs, ch1 sends 1 → only ch1 is output; drop_cnt=2; seq[0] stays 0; ch0 s_tready=1 during its beats.
- MAX_BEATS=4, ch0 sends a 7-beat TLP → 5 output beats (header + 4 data); beat 5 has m_tlast=1 and m_tuser=1; remaining 3 beats consumed silently; trunc_cnt=1; the next TLP is forwarded normally.
- Preload seq[0]=0xFFFF via 65535 TLPs, send one more → its header seq=0xFFFF and the next header shows 0x0000. Toggle m_tready randomly during packets → no beat lost or duplicated.
- Assert eth_rst_n=0 mid-DATA → all outputs 0 immediately; after release, a new TLP yields header seq=0 and fwd_cnt=1.
